// File: rtl/pac_arm_pkg.sv
// rtl/pac_arm_pkg.sv - shared Pac-ARM execute-stage types and widths
package pac_arm_pkg;

  localparam int ANCHO_DATO = 32;

  typedef enum logic [1:0] {ESPERA, CALCULO, FIN} estado_mult_t;

endpackage

// File: rtl/sumador32bit.sv
// rtl/sumador32bit.sv - 32-bit ripple adder with carry in/out
module sumador32bit
  import pac_arm_pkg::*;
(
  input  logic [ANCHO_DATO-1:0] datoA,
  input  logic [ANCHO_DATO-1:0] datoB,
  input  logic                  carryIn,
  output logic [ANCHO_DATO-1:0] suma,
  output logic                  c
);

  assign {c, suma} = {1'b0, datoA} + {1'b0, datoB} + {{ANCHO_DATO{1'b0}}, carryIn};

endmodule

// File: rtl/multiplicador_secuencial.sv
// rtl/multiplicador_secuencial.sv - 32-iteration unsigned shift-add multiplier
// Optional MULT_RESULTADO64_EN exposes the high product word and 64-bit flags.
module multiplicador_secuencial
  import pac_arm_pkg::*;
#(
  parameter int ANCHO = ANCHO_DATO
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [ANCHO-1:0] datoA,
  input  logic [ANCHO-1:0] datoB,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] resultado,
`ifdef MULT_RESULTADO64_EN
  output logic [ANCHO-1:0] resultadoAlto,
`endif
  output logic             negativo,
  output logic             cero
);

  localparam int CONT_W = $clog2(ANCHO) + 1;

  estado_mult_t      estado, estadoSig;
  logic [ANCHO-1:0]  regA, regAlto, regBajo;
  logic [CONT_W-1:0] contador;
  logic [ANCHO-1:0]  sumandoB, suma;
  logic              c;

  assign sumandoB = regBajo[0] ? regA : '0;

  sumador32bit uSumador (
    .datoA  (regAlto),
    .datoB  (sumandoB),
    .carryIn(1'b0),
    .suma   (suma),
    .c      (c)
  );

  always_comb begin
    estadoSig = estado;
    ocupado   = 1'b0;
    listo     = 1'b0;
    case (estado)
      ESPERA:  if (inicio) estadoSig = CALCULO;
      CALCULO: begin
        ocupado = 1'b1;
        if (contador == CONT_W'(ANCHO - 1)) estadoSig = FIN;
      end
      FIN: begin
        ocupado   = 1'b1;
        listo     = 1'b1;
        estadoSig = ESPERA;
      end
      default: estadoSig = ESPERA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= ESPERA;
      regA     <= '0;
      regAlto  <= '0;
      regBajo  <= '0;
      contador <= '0;
    end else begin
      estado <= estadoSig;
      case (estado)
        ESPERA: if (inicio) begin
          regA     <= datoA;
          regAlto  <= '0;
          regBajo  <= datoB;
          contador <= '0;
        end
        // Adder carry lands in regAlto's MSB so the 64-bit product never overflows.
        CALCULO: begin
          {regAlto, regBajo} <= {c, suma, regBajo[ANCHO-1:1]};
          contador           <= contador + CONT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign resultado = regBajo;
`ifdef MULT_RESULTADO64_EN
  assign resultadoAlto = regAlto;
  assign negativo      = regAlto[ANCHO-1];
  assign cero          = ({regAlto, regBajo} == '0);
`else
  assign negativo      = regBajo[ANCHO-1];
  assign cero          = (regBajo == '0);
`endif

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// tb/tb_multiplicador_secuencial.sv - scoreboard bench for multiplicador_secuencial
module tb_multiplicador_secuencial;

  logic        clk = 1'b0;
  logic        rst, inicio;
  logic [31:0] datoA, datoB, resultado;
  logic        ocupado, listo, negativo, cero;
`ifdef MULT_RESULTADO64_EN
  logic [31:0] resultadoAlto;
`endif

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        neg;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multiplicador_secuencial dut (
    .clk          (clk),
    .rst          (rst),
    .inicio       (inicio),
    .datoA        (datoA),
    .datoB        (datoB),
    .ocupado      (ocupado),
    .listo        (listo),
    .resultado    (resultado),
`ifdef MULT_RESULTADO64_EN
    .resultadoAlto(resultadoAlto),
`endif
    .negativo     (negativo),
    .cero         (cero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t modelo(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    p      = {32'd0, a} * {32'd0, b};
    e.lo   = p[31:0];
    e.hi   = p[63:32];
`ifdef MULT_RESULTADO64_EN
    e.neg  = p[63];
    e.zero = (p == 64'd0);
`else
    e.neg  = p[31];
    e.zero = (p[31:0] == 32'd0);
`endif
    return e;
  endfunction

  // Monitor: every listo pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (listo) begin
      if (sb.size() == 0) begin
        check("unexpected_listo", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resultado", {32'd0, resultado}, {32'd0, e.lo});
        check("negativo", {63'd0, negativo}, {63'd0, e.neg});
        check("cero", {63'd0, cero}, {63'd0, e.zero});
`ifdef MULT_RESULTADO64_EN
        check("resultadoAlto", {32'd0, resultadoAlto}, {32'd0, e.hi});
`endif
      end
    end
  end

  // One accepted start from idle; checks latency, busy window and ignored pulses.
  task automatic runMul(input logic [31:0] a, input logic [31:0] b, input bit pulsos);
    int lat, ocup, nListo;
    datoA  = a;
    datoB  = b;
    inicio = 1'b1;
    sb.push_back(modelo(a, b));
    @(posedge clk);
    #1;
    inicio = 1'b0;
    datoA  = $urandom;
    datoB  = $urandom;
    lat = -1; ocup = 0; nListo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (listo) begin
        nListo++;
        if (lat < 0) lat = i;
      end
      if (ocupado) ocup++;
      if (pulsos) begin
        if (i == 5 || i == 32) inicio = 1'b1;
        if (i == 6 || i == 33) inicio = 1'b0;
      end
      if (i == 12) begin
        datoA = $urandom;
        datoB = $urandom;
      end
    end
    check("latencia_listo", 64'(lat), 64'd32);
    check("ciclos_ocupado", 64'(ocup), 64'd33);
    check("pulsos_listo", 64'(nListo), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inicio = 1'b0; datoA = '0; datoB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ocupado", {63'd0, ocupado}, 64'd0);
    check("reset_listo", {63'd0, listo}, 64'd0);
    check("reset_resultado", {32'd0, resultado}, 64'd0);
    check("reset_cero", {63'd0, cero}, 64'd1);
    check("reset_negativo", {63'd0, negativo}, 64'd0);
`ifdef MULT_RESULTADO64_EN
    check("reset_resultadoAlto", {32'd0, resultadoAlto}, 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    runMul(32'd45, 32'd45, 1'b0);
    runMul(32'd23845, 32'd5645, 1'b0);
    runMul(32'd4294967290, 32'd4294967290, 1'b0);
    runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    runMul(32'd0, $urandom, 1'b0);
    runMul($urandom, 32'd0, 1'b0);
    runMul(32'd7, 32'd9, 1'b1);

    // Back-to-back with inicio held high: second start lands on the first idle edge.
    begin
      int idx[$];
      datoA = 32'd0; datoB = 32'd325; inicio = 1'b1;
      sb.push_back(modelo(32'd0, 32'd325));
      sb.push_back(modelo(32'd1, 32'd425));
      @(posedge clk); #1;
      datoA = 32'd1; datoB = 32'd425;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (listo) idx.push_back(i);
        if (i == 33) check("b2b_ocupado_espera", {63'd0, ocupado}, 64'd0);
        if (i == 40) inicio = 1'b0;
      end
      check("b2b_num_listo", 64'(idx.size()), 64'd2);
      if (idx.size() == 2) begin
        check("b2b_listo_1", 64'(idx[0]), 64'd32);
        check("b2b_listo_2", 64'(idx[1]), 64'd66);
      end
    end

    // Abort mid-calculation: no product is expected from it.
    datoA = 32'hDEAD_BEEF; datoB = 32'h1234_5678; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 9) rst = 1'b1;
      if (i == 10) begin
        check("abort_ocupado", {63'd0, ocupado}, 64'd0);
        check("abort_resultado", {32'd0, resultado}, 64'd0);
        check("abort_cero", {63'd0, cero}, 64'd1);
        check("abort_listo", {63'd0, listo}, 64'd0);
        rst = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    runMul(32'd2342, 32'd4348345, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (n % 5 == 1) a = a >> $urandom_range(31, 0);
      if (n % 5 == 2) b = b >> $urandom_range(31, 0);
      runMul(a, b, n[0]);
    end

    // Outputs hold in idle after the last product.
    begin
      exp_t e;
      e = modelo(32'hCAFE_0001, 32'h0000_0003);
      runMul(32'hCAFE_0001, 32'h0000_0003, 1'b0);
      repeat (5) @(negedge clk);
      check("hold_resultado", {32'd0, resultado}, {32'd0, e.lo});
    end

    check("scoreboard_vacio", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
